// File: rtl/branch_predict_unit_if.sv
// Fetch/EX pipeline bundle for the branch predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_ir;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_ir;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic            ex_pred_taken;
  logic [1:0]      pc_sel;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispredict_cnt;

  modport master (
    output if_pc, if_ir, ex_valid, ex_pc, ex_ir, ex_rs1, ex_rs2, ex_pred_taken,
    input  pred_taken, pred_target, pc_sel, redirect_valid, redirect_pc,
           branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, if_ir, ex_valid, ex_pc, ex_ir, ex_rs1, ex_rs2, ex_pred_taken,
    output pred_taken, pred_target, pc_sel, redirect_valid, redirect_pc,
           branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters looked up
// at fetch and trained at EX, plus branch resolution, redirect generation
// and branch / mispredict statistics.
module branch_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int         IDX_W     = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]      bht [BHT_DEPTH];
  logic [31:0]     branch_cnt_q;
  logic [31:0]     mispredict_cnt_q;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [6:0]       ex_op;
  logic [2:0]       ex_f3;
  logic             ex_taken;
  logic             bht_update;
  logic [XLEN-1:0]  jalr_sum;
  logic [1:0]       pc_sel_c;
  logic             redirect_valid_c;
  logic [XLEN-1:0]  redirect_pc_c;
  logic             unused_if_ir_bits;

  // func3 010 and 011 are not defined for conditional branches
  function automatic logic func3_ok(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic logic [XLEN-1:0] b_imm(input logic [31:0] ir);
    return {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] j_imm(input logic [31:0] ir);
    return {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] i_imm(input logic [31:0] ir);
    return {{(XLEN-12){ir[31]}}, ir[31:20]};
  endfunction

  assign if_idx   = bus.if_pc[IDX_W+1:2];
  assign ex_idx   = bus.ex_pc[IDX_W+1:2];
  assign ex_op    = bus.ex_ir[6:0];
  assign ex_f3    = bus.ex_ir[14:12];
  assign jalr_sum = bus.ex_rs1 + i_imm(bus.ex_ir);

  // rs1/rs2 fields of the fetch instruction play no part in prediction
  assign unused_if_ir_bits = ^bus.if_ir[24:15];

  // Fetch prediction reads the table as it stands; no bypass from EX
  assign bus.pred_taken  = (bus.if_ir[6:0] == OP_BRANCH) && func3_ok(bus.if_ir[14:12])
                           && bht[if_idx][1];
  assign bus.pred_target = bus.if_pc + b_imm(bus.if_ir);

  // Resolve the EX branch condition with full-width compares
  always_comb begin
    ex_taken = 1'b0;
    case (ex_f3)
      3'b000:  ex_taken = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  ex_taken = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  ex_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  ex_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  ex_taken = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  ex_taken = (bus.ex_rs1 >= bus.ex_rs2);
      default: ex_taken = 1'b0;
    endcase
  end

  assign bht_update = bus.ex_valid && (ex_op == OP_BRANCH) && func3_ok(ex_f3);

  // Select next PC source and raise a redirect for jumps and wrong predictions
  always_comb begin
    pc_sel_c         = 2'b00;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;
    if (bus.ex_valid) begin
      if (ex_op == OP_JAL) begin
        pc_sel_c         = 2'b11;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = bus.ex_pc + j_imm(bus.ex_ir);
      end else if (ex_op == OP_JALR) begin
        pc_sel_c         = 2'b01;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (ex_op == OP_BRANCH) begin
        if (ex_taken) begin
          pc_sel_c = 2'b10;
        end
        if (ex_taken != bus.ex_pred_taken) begin
          redirect_valid_c = 1'b1;
          redirect_pc_c    = ex_taken ? (bus.ex_pc + b_imm(bus.ex_ir))
                                      : (bus.ex_pc + XLEN'(4));
        end
      end
    end
  end

  assign bus.pc_sel         = pc_sel_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  // Train the addressed counter toward the resolved outcome, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (bht_update) begin
      if (ex_taken && (bht[ex_idx] != 2'b11)) begin
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else if (!ex_taken && (bht[ex_idx] != 2'b00)) begin
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // Count resolved branches and wrong predictions, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bht_update) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if ((ex_taken != bus.ex_pred_taken) && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized scoreboard bench for branch_predict_unit against an
// instruction-level reference model that works from immediates as integers.
module tb_branch_predict_unit;
  localparam int XLEN      = 32;
  localparam int BHT_DEPTH = 64;

  typedef enum {K_BRANCH, K_JAL, K_JALR, K_OTHER} kind_e;

  typedef struct {
    kind_e      kind;
    logic [2:0] f3;
    int         imm;
  } instr_t;

  typedef struct {
    string       tag;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pc_sel;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

  branch_predict_unit #(
    .XLEN(XLEN),
    .BHT_DEPTH(BHT_DEPTH),
    .CTR_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  int          ctr[BHT_DEPTH];
  int unsigned bcnt;
  int unsigned mcnt;

  function automatic instr_t mk(kind_e k, logic [2:0] f3, int imm);
    instr_t r;
    r.kind = k;
    r.f3   = f3;
    r.imm  = imm;
    return r;
  endfunction

  // Non-branch "other" uses the branch layout with an R-type opcode
  function automatic logic [31:0] encode(instr_t ins);
    logic [31:0] u;
    u = ins.imm;
    case (ins.kind)
      K_BRANCH: return {u[12], u[10:5], 5'd2, 5'd1, ins.f3, u[4:1], u[11], 7'b1100011};
      K_JAL:    return {u[20], u[10:1], u[11], u[19:12], 5'd1, 7'b1101111};
      K_JALR:   return {u[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
      default:  return {u[12], u[10:5], 5'd2, 5'd1, ins.f3, u[4:1], u[11], 7'b0110011};
    endcase
  endfunction

  function automatic bit legal(logic [2:0] f3);
    return !(f3 == 3'd2 || f3 == 3'd3);
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  function automatic bit outcome(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return int'(a) < int'(b);
      3'd5:    return int'(a) >= int'(b);
      3'd6:    return longint'(a) < longint'(b);
      3'd7:    return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < BHT_DEPTH; i++) ctr[i] = 1;
    bcnt = 0;
    mcnt = 0;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue the model's expectation, then apply the model's edge effect
  task automatic applyStimulus(string tag, instr_t fi, logic [31:0] fpc, bit ev, instr_t ei,
                               logic [31:0] epc, logic [31:0] rs1, logic [31:0] rs2, bit ept);
    exp_t e;
    bit taken;
    @(negedge clk);
    bus.if_pc         = fpc;
    bus.if_ir         = encode(fi);
    bus.ex_valid      = ev;
    bus.ex_pc         = epc;
    bus.ex_ir         = encode(ei);
    bus.ex_rs1        = rs1;
    bus.ex_rs2        = rs2;
    bus.ex_pred_taken = ept;
    e.tag            = tag;
    e.pred_taken     = (fi.kind == K_BRANCH) && legal(fi.f3) && (ctr[idx_of(fpc)] >= 2);
    e.pred_target    = fpc + 32'(fi.imm);
    e.pc_sel         = 2'd0;
    e.redirect_valid = 1'b0;
    e.redirect_pc    = 32'd0;
    taken = 1'b0;
    if (ev) begin
      case (ei.kind)
        K_JAL: begin
          e.pc_sel = 2'd3; e.redirect_valid = 1'b1; e.redirect_pc = epc + 32'(ei.imm);
        end
        K_JALR: begin
          e.pc_sel = 2'd1; e.redirect_valid = 1'b1;
          e.redirect_pc = (rs1 + 32'(ei.imm)) & 32'hFFFF_FFFE;
        end
        K_BRANCH: begin
          taken = outcome(ei.f3, rs1, rs2);
          e.pc_sel = taken ? 2'd2 : 2'd0;
          if (taken != ept) begin
            e.redirect_valid = 1'b1;
            e.redirect_pc = taken ? epc + 32'(ei.imm) : epc + 32'd4;
          end
        end
        default: ;
      endcase
    end
    e.branch_cnt     = bcnt;
    e.mispredict_cnt = mcnt;
    exp_q.push_back(e);
    #1 -> sample_ev;
    if (rst_n && ev && ei.kind == K_BRANCH && legal(ei.f3)) begin
      if (taken) ctr[idx_of(epc)] = (ctr[idx_of(epc)] == 3) ? 3 : ctr[idx_of(epc)] + 1;
      else       ctr[idx_of(epc)] = (ctr[idx_of(epc)] == 0) ? 0 : ctr[idx_of(epc)] - 1;
      bcnt++;
      if (taken != ept) mcnt++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd5;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop one expectation per presented sample and compare every output
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_sample: got sample expected none");
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.tag, ".pred_taken"},     32'(bus.pred_taken),     32'(e.pred_taken));
        checkOutput({e.tag, ".pred_target"},    bus.pred_target,         e.pred_target);
        checkOutput({e.tag, ".pc_sel"},         32'(bus.pc_sel),         32'(e.pc_sel));
        checkOutput({e.tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(e.redirect_valid));
        checkOutput({e.tag, ".redirect_pc"},    bus.redirect_pc,         e.redirect_pc);
        checkOutput({e.tag, ".branch_cnt"},     bus.branch_cnt,          e.branch_cnt);
        checkOutput({e.tag, ".mispredict_cnt"}, bus.mispredict_cnt,      e.mispredict_cnt);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t beq, nop, fi, ei;
    logic [31:0] fpc, epc;
    bus.if_pc = '0; bus.if_ir = '0; bus.ex_valid = 1'b0; bus.ex_pc = '0;
    bus.ex_ir = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_pred_taken = 1'b0;
    modelReset();
    beq = mk(K_BRANCH, 3'd0, 64);
    nop = mk(K_OTHER, 3'd0, 0);

    applyStimulus("reset_state", beq, 32'h100, 1'b1, beq, 32'h100, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++)
      applyStimulus("beq_train", beq, 32'h100, 1'b1, beq, 32'h100, 32'd5, 32'd5, 1'b0);
    applyStimulus("beq_after", beq, 32'h100, 1'b0, nop, 32'h0, 32'd0, 32'd0, 1'b0);

    applyStimulus("blt_taken", nop, 32'h0, 1'b1, mk(K_BRANCH, 3'd4, -32), 32'h200,
                  32'hFFFF_FFFF, 32'd1, 1'b1);
    applyStimulus("bltu_not", nop, 32'h0, 1'b1, mk(K_BRANCH, 3'd6, -32), 32'h200,
                  32'hFFFF_FFFF, 32'd1, 1'b1);
    applyStimulus("jalr", beq, 32'h100, 1'b1, mk(K_JALR, 3'd0, 2), 32'h300,
                  32'h1001, 32'd0, 1'b0);
    applyStimulus("jal", beq, 32'h100, 1'b1, mk(K_JAL, 3'd0, -2048), 32'h300,
                  32'd0, 32'd0, 1'b0);
    applyStimulus("f3_010", beq, 32'h100, 1'b1, mk(K_BRANCH, 3'd2, 16), 32'h100,
                  32'd5, 32'd5, 1'b1);
    applyStimulus("ex_invalid", beq, 32'h100, 1'b0, beq, 32'h100, 32'd5, 32'd5, 1'b0);
    applyStimulus("post_idle", beq, 32'h100, 1'b0, nop, 32'h0, 32'd0, 32'd0, 1'b0);

    // Asynchronous reset between edges; the update presented meanwhile is discarded
    @(posedge clk);
    #2 rst_n = 1'b0;
    modelReset();
    applyStimulus("mid_reset", beq, 32'h100, 1'b1, beq, 32'h100, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    rst_n = 1'b1;
    applyStimulus("after_reset", beq, 32'h100, 1'b0, nop, 32'h0, 32'd0, 32'd0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      fpc = 32'h1000 + ($urandom_range(0, 127) << 2);
      epc = 32'h1000 + ($urandom_range(0, 127) << 2);
      fi = mk(($urandom_range(0, 4) == 0) ? K_OTHER : K_BRANCH, 3'($urandom_range(0, 7)),
              (int'($urandom_range(0, 4095)) - 2048) * 2);
      case ($urandom_range(0, 9))
        0:       ei = mk(K_JAL, 3'd0, (int'($urandom_range(0, 1048575)) - 524288) * 2);
        1:       ei = mk(K_JALR, 3'd0, int'($urandom_range(0, 4095)) - 2048);
        2:       ei = mk(K_OTHER, 3'($urandom_range(0, 7)), 0);
        default: ei = mk(K_BRANCH, 3'($urandom_range(0, 7)),
                         (int'($urandom_range(0, 4095)) - 2048) * 2);
      endcase
      applyStimulus("random", fi, fpc, ($urandom_range(0, 3) != 0), ei, epc,
                    pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, data/PC width; legal values 32 or 64.
REQ-002 Parameter BHT_DEPTH, default 64, number of 2-bit counters; power of 2, >=2; IDX_W = log2(BHT_DEPTH).
REQ-003 Parameter CTR_INIT, default 2'b01, counter reset value (weakly not-taken).
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 if_pc  in  XLEN  fetch-stage PC.
REQ-007 if_ir  in  32  fetch-stage instruction.
REQ-008 pred_taken  out  1  fetch prediction, combinational.
REQ-009 pred_target  out  XLEN  if_pc + B-immediate(if_ir), combinational.
REQ-010 ex_valid  in  1  EX-stage instruction valid, not stalled/flushed.
REQ-011 ex_pc  in  XLEN  EX-stage PC.
REQ-012 ex_ir  in  32  EX-stage instruction.
REQ-013 ex_rs1, ex_rs2  in  XLEN each  EX-stage operands.
REQ-014 ex_pred_taken  in  1  pred_taken value piped with the EX instruction.
REQ-015 PC_SEL  out  2  00 seq, 01 JALR, 10 branch taken, 11 JAL.
REQ-016 redirect_valid  out  1  fetch must flush and load redirect_pc.
REQ-017 redirect_pc  out  XLEN  corrected next PC.
REQ-018 branch_cnt, mispredict_cnt  out  32 each  statistics counters.

Function
REQ-019 Index = pc[IDX_W+1:2] for both lookup (if_pc) and update (ex_pc).
REQ-020 pred_taken = 1 iff if_ir[6:0]=1100011, func3 in {000,001,100,101,110,111}, and BHT[idx][1]=1.
REQ-021 Outcomes: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge, full XLEN compare; func3 010/011 = not taken.
REQ-022 PC_SEL = 00 when ex_valid=0; else 11 JAL (1101111), 01 JALR (1100111), 10 valid branch taken, 00 otherwise.
REQ-023 redirect_valid = ex_valid & (JAL | JALR | (opcode 1100011 & taken != ex_pred_taken)).
REQ-024 redirect_pc: JAL ex_pc+J-imm; JALR (ex_rs1+I-imm) with bit0 cleared; taken branch ex_pc+B-imm; not-taken mispredict ex_pc+4; 0 when redirect_valid=0.
REQ-025 All adds are modulo 2^XLEN; immediates sign-extended to XLEN.
REQ-026 At posedge CLK with ex_valid and valid-func3 branch: BHT[ex idx] increments if taken, decrements if not, saturating at 11 and 00.
REQ-027 Illegal func3, non-branches, and ex_valid=0 cause no BHT or statistics change.
REQ-028 Same-cycle lookup and update of one index: pred_taken uses pre-update value; no bypass.
REQ-029 At each valid-func3 branch update, branch_cnt += 1; mispredict_cnt += 1 if taken != ex_pred_taken; both saturate at 32'hFFFF_FFFF.
REQ-030 All outputs except registered state are combinational from current inputs; update latency 1 cycle.

Reset
REQ-031 RST_N=0 asynchronously sets every BHT entry to CTR_INIT and both statistics counters to 0, regardless of CLK.
REQ-032 Reset mid-operation discards any same-cycle update; first update after RST_N rises applies at the next posedge.
REQ-033 During reset, combinational outputs follow inputs using reset state; with CTR_INIT=01, pred_taken=0.

Verification
REQ-034 Reset, then if_ir=BEQ at if_pc=0x100 -> pred_taken=0, pred_target=0x100+imm, counters 0.
REQ-035 Three valid BEQ updates at ex_pc=0x100 with rs1=rs2=5, ex_pred_taken=0 -> first cycle redirect_valid=1, redirect_pc=0x100+imm, PC_SEL=10; BHT saturates at 11; branch_cnt=3; pred_taken for 0x100 becomes 1 after the first update.
REQ-036 BLT, rs1=0xFFFFFFFF, rs2=1, ex_pred_taken=1 -> taken, no redirect; same with BLTU -> not taken, redirect_pc=ex_pc+4, mispredict_cnt+1.
REQ-037 JALR, rs1=0x1001, imm=2 -> PC_SEL=01, redirect_pc=0x1002; JAL -> PC_SEL=11; no BHT or counter change.
REQ-038 func3=010 with ex_valid=1, and any branch with ex_valid=0 -> no BHT or counter change, PC_SEL=00.
REQ-039 Assert RST_N low between clock edges after updates -> BHT immediately CTR_INIT, counters 0.
